// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_state_e : clear-sequencer state encoding (CLEAR, READY)
//   clog2      : ceiling log2, usable in parameter expressions
//   rf_addr_t  : register address type for the default 32-entry file
package regfile_pkg;

    typedef enum logic {CLEAR, READY} rf_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    localparam int unsigned RF_DEFAULT_DEPTH = 32;
    localparam int unsigned RF_DEFAULT_AW    = clog2(RF_DEFAULT_DEPTH);

    typedef logic [RF_DEFAULT_AW-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus interface of the multi-port register file.
//   clear_req : pulse requesting a new clear sequence
//   rd_addr   : packed read addresses, port i at [i*AW +: AW]
//   rd_data   : packed combinational read data, port i at [i*DATA_W +: DATA_W]
//   wr_en     : per-port write enable
//   wr_addr   : packed write addresses
//   wr_data   : packed write data
//   ready     : clear complete, writes accepted
//   wr_drop   : one-cycle flag after a write was ignored during clear
// master = pipeline side, slave = register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned AW     = clog2(DEPTH)
);

    logic                     clear_req;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     ready;
    logic                     wr_drop;

    modport master (
        output clear_req, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, ready, wr_drop
    );

    modport slave (
        input  clear_req, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, ready, wr_drop
    );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: after reset or an accepted clear_req, zeroes entries
// 1..DEPTH-1, one per clock, then raises ready.
//   clk, rst  : clock, asynchronous active-high reset
//   clear_req : restart request, honoured only in READY
//   ready     : registered, 1 once the clear has completed
//   clr_we    : array write enable for the clearing write
//   clr_addr  : entry being cleared this cycle
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= AW'(1);
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    // The last entry is zeroed on the same edge that leaves CLEAR.
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                READY: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= AW'(1);
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= AW'(1);
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD asynchronous read ports,
// NUM_WR write ports (highest index wins on conflict), entry 0 reads zero.
// Storage has no reset; regfile_clear_fsm zeroes it after reset/clear_req.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : regfile_mp_if slave (read/write ports, clear_req, ready, wr_drop)
// Optional macro REGFILE_BYPASS_EN: a read matching an active, non-zero
// write port returns that port's wr_data in the same cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);

    localparam int unsigned AW = clog2(DEPTH);

    typedef logic [AW-1:0] rf_addr_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic     ready;
    logic     clr_we;
    rf_addr_t clr_addr;

    rf_addr_t          ra [NUM_RD];
    rf_addr_t          wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];

    regfile_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear_req (bus.clear_req),
        .ready     (ready),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign bus.ready = ready;

    always_comb begin
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            ra[r] = bus.rd_addr[r*AW +: AW];
        end
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            wa[p] = bus.wr_addr[p*AW +: AW];
            wd[p] = bus.wr_data[p*DATA_W +: DATA_W];
        end
    end

    // Ascending port loop: a later non-blocking write to the same entry
    // overrides an earlier one, so the highest port index wins.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (ready) begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (bus.wr_en[p] && (wa[p] != '0)) begin
                    mem[wa[p]] <= wd[p];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_drop <= 1'b0;
        end else begin
            bus.wr_drop <= !ready && (|bus.wr_en);
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            if (ready && (ra[r] != '0)) begin
                bus.rd_data[r*DATA_W +: DATA_W] = mem[ra[r]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned p = 0; p < NUM_WR; p++) begin
                    if (bus.wr_en[p] && (wa[p] == ra[r])) begin
                        bus.rd_data[r*DATA_W +: DATA_W] = wd[p];
                    end
                end
`endif
            end
        end
    end

endmodule
